bus_dma_master: RTL and testbench
=================================

BUS_DMA_MASTER -- requirements
Module: bus_dma_master

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, bus data/address width.
REQ-002 SHALL have parameter CTRL_WIDTH, default 8, control bus width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, transfer length counter width.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for slave ready.
REQ-005 SHALL have ports: clk in 1, sole clock, rising edge; rst in 1, asynchronous, active-high reset.
REQ-006 SHALL have ports: start in 1, begin copy, one-cycle pulse; src_addr in BUS_WIDTH, first source word; dst_addr in BUS_WIDTH, first destination word; len in LEN_WIDTH, word count.
REQ-007 SHALL have ports: busy out 1, copy in progress; done out 1, one-cycle completion pulse; error out 1, sticky timeout flag; words_done out LEN_WIDTH, words written so far.
REQ-008 SHALL have ports: req out 1, bus request to arbiter; ack in 1, grant from arbiter.
REQ-009 SHALL have ports: bus_in in BUS_WIDTH, shared bus; bus_out out BUS_WIDTH, master drive; ctrl_in in CTRL_WIDTH, shared control; ctrl_out out CTRL_WIDTH, master control drive.

Function
REQ-010 SHALL copy len 32-bit words from src_addr..src_addr+len-1 to dst_addr..dst_addr+len-1 through the arbitrated bus, one read then one write per word.
REQ-011 SHALL latch src_addr, dst_addr, len on start only in IDLE; start while busy SHALL be ignored.
REQ-012 SHALL implement states IDLE, RD_REQ, RD_ADDR, RD_WAIT, WR_REQ, WR_ADDR, WR_DATA, REL, DONE, ERR.
REQ-013 RD_REQ/WR_REQ: assert req; advance to RD_ADDR/WR_ADDR on the first cycle ack=1.
REQ-014 RD_ADDR: drive bus_out=current source address, ctrl_out=CMD_READ for exactly one cycle, then RD_WAIT.
REQ-015 RD_WAIT: on ctrl_in[CTRL_RDY]=1 capture bus_in into the data register that cycle, go REL then WR_REQ.
REQ-016 WR_ADDR: drive bus_out=current destination address, ctrl_out=CMD_WRITE for one cycle; WR_DATA: hold bus_out=data register, ctrl_out=CMD_WDATA until ctrl_in[CTRL_RDY]=1.
REQ-017 After write acceptance SHALL increment both addresses by 1 (modulo 2^BUS_WIDTH, wrap silent), increment words_done, go REL.
REQ-018 REL SHALL deassert req for exactly one cycle, then go RD_REQ if words_done<len else DONE.
REQ-019 req SHALL stay asserted continuously from the REQ state through RD_WAIT/WR_DATA completion.
REQ-020 bus_out and ctrl_out SHALL be all-zero whenever ack=0 or state is IDLE/REL/DONE/ERR.
REQ-021 DONE SHALL pulse done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-022 len=0 SHALL produce done one cycle after start with no req assertion.
REQ-023 A timeout counter SHALL count cycles in RD_WAIT/WR_DATA; reaching TIMEOUT without ready SHALL go ERR.
REQ-024 ack falling to 0 while in RD_ADDR..WR_DATA SHALL go ERR.
REQ-025 ERR SHALL deassert req, set error=1, then IDLE; error SHALL clear on next accepted start.
REQ-026 words_done SHALL hold its final value in IDLE until next accepted start clears it.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, req=0, busy=0, done=0, error=0, words_done=0, bus_out=0, ctrl_out=0, address/data/timeout registers 0.
REQ-028 rst asserted mid-transfer SHALL abandon the transfer with no further bus activity after release.

Structure
REQ-029 Control bit positions and command encodings (CTRL_RDY=bit 0, CMD_READ, CMD_WRITE, CMD_WDATA) SHALL live in the shared bus package used by the SRAM controller and arbiter.
REQ-030 SHALL be one module with no sub-modules; FSM, counters, and address registers are local.

Verification
REQ-031 len=4, src=0x10, dst=0x100, slave ready after 2 cycles -> words 0x10..0x13 appear at 0x100..0x103, words_done=4, one done pulse, error=0.
REQ-032 len=0 start -> done one cycle later, req never asserted, busy high exactly one cycle.
REQ-033 Slave never asserts ready, TIMEOUT=8 -> ERR after 8 wait cycles, req low, error=1, busy=0; next start clears error.
REQ-034 dst=0xFFFFFFFF, len=2 -> second write to address 0x00000000.
REQ-035 ack withheld 10 cycles by competing requester -> no bus drive until ack, then normal completion; req low exactly one cycle between words.
REQ-036 rst pulsed during WR_DATA of word 2 -> req and ctrl_out zero same cycle, words_done=0, no done pulse.

Source files
------------

// File: rtl/bus_dma_master_pkg.sv
// Shared bus definitions: control bit positions, command encodings and DMA master states.
// The SRAM controller and arbiter import the same constants.
package bus_dma_master_pkg;

    localparam int unsigned CTRL_RDY = 0;

    localparam logic [7:0] CMD_IDLE  = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_WRITE = 8'h04;
    localparam logic [7:0] CMD_WDATA = 8'h08;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_REQ  = 4'd1,
        S_RD_ADDR = 4'd2,
        S_RD_WAIT = 4'd3,
        S_WR_REQ  = 4'd4,
        S_WR_ADDR = 4'd5,
        S_WR_DATA = 4'd6,
        S_REL     = 4'd7,
        S_DONE    = 4'd8,
        S_ERR     = 4'd9
    } dma_state_e;

    // States in which the master owns the bus and therefore depends on ack staying high.
    function automatic logic holds_bus(input dma_state_e s);
        return (s == S_RD_ADDR) || (s == S_RD_WAIT) || (s == S_WR_ADDR) || (s == S_WR_DATA);
    endfunction

    // States that wait on slave ready and are guarded by the timeout counter.
    function automatic logic waits_slave(input dma_state_e s);
        return (s == S_RD_WAIT) || (s == S_WR_DATA);
    endfunction

endpackage

// File: rtl/bus_dma_master.sv
// Word-copy DMA master on an arbitrated shared bus: one read then one write per word,
// releasing the bus for one cycle after every bus transaction.
module bus_dma_master
    import bus_dma_master_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BUS_WIDTH-1:0]  src_addr,
    input  logic [BUS_WIDTH-1:0]  dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  words_done,
    output logic                  req,
    input  logic                  ack,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    output logic [BUS_WIDTH-1:0]  bus_out,
    input  logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic [CTRL_WIDTH-1:0] ctrl_out
);

    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    dma_state_e            state_q;
    logic [BUS_WIDTH-1:0]  src_q;
    logic [BUS_WIDTH-1:0]  dst_q;
    logic [BUS_WIDTH-1:0]  data_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  words_q;
    logic [TMO_W-1:0]      tmo_q;
    logic                  wr_phase_q;
    logic                  req_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  rdy_d;
    logic                  abort_d;
    logic [BUS_WIDTH-1:0]  bus_drv_d;
    logic [CTRL_WIDTH-1:0] ctrl_drv_d;
    logic                  unused_ctrl;

    assign rdy_d       = ctrl_in[CTRL_RDY];
    assign unused_ctrl = ^ctrl_in;

    // Lost grant while owning the bus, or slave silent for TIMEOUT wait cycles.
    assign abort_d = holds_bus(state_q) &&
                     (!ack || (waits_slave(state_q) && !rdy_d && (tmo_q == TMO_LAST)));

    always_comb begin
        bus_drv_d  = '0;
        ctrl_drv_d = '0;
        unique case (state_q)
            S_RD_ADDR: begin
                bus_drv_d  = src_q;
                ctrl_drv_d = CTRL_WIDTH'(CMD_READ);
            end
            S_WR_ADDR: begin
                bus_drv_d  = dst_q;
                ctrl_drv_d = CTRL_WIDTH'(CMD_WRITE);
            end
            S_WR_DATA: begin
                bus_drv_d  = data_q;
                ctrl_drv_d = CTRL_WIDTH'(CMD_WDATA);
            end
            default: begin
                bus_drv_d  = '0;
                ctrl_drv_d = '0;
            end
        endcase
    end

    // Drive is forced to zero the moment the grant disappears.
    assign bus_out    = ack ? bus_drv_d  : '0;
    assign ctrl_out   = ack ? ctrl_drv_d : '0;
    assign req        = req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_done = words_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            len_q      <= '0;
            words_q    <= '0;
            tmo_q      <= '0;
            wr_phase_q <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_d) begin
                state_q <= S_ERR;
                req_q   <= 1'b0;
                error_q <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            src_q      <= src_addr;
                            dst_q      <= dst_addr;
                            len_q      <= len;
                            words_q    <= '0;
                            tmo_q      <= '0;
                            wr_phase_q <= 1'b0;
                            error_q    <= 1'b0;
                            busy_q     <= 1'b1;
                            if (len == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_RD_REQ;
                                req_q   <= 1'b1;
                            end
                        end
                    end
                    S_RD_REQ: begin
                        if (ack) state_q <= S_RD_ADDR;
                    end
                    S_RD_ADDR: begin
                        state_q <= S_RD_WAIT;
                        tmo_q   <= '0;
                    end
                    S_RD_WAIT: begin
                        if (rdy_d) begin
                            data_q     <= bus_in;
                            wr_phase_q <= 1'b1;
                            req_q      <= 1'b0;
                            state_q    <= S_REL;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    S_WR_REQ: begin
                        if (ack) state_q <= S_WR_ADDR;
                    end
                    S_WR_ADDR: begin
                        state_q <= S_WR_DATA;
                        tmo_q   <= '0;
                    end
                    S_WR_DATA: begin
                        if (rdy_d) begin
                            src_q      <= src_q + BUS_WIDTH'(1);
                            dst_q      <= dst_q + BUS_WIDTH'(1);
                            words_q    <= words_q + LEN_WIDTH'(1);
                            wr_phase_q <= 1'b0;
                            req_q      <= 1'b0;
                            state_q    <= S_REL;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    S_REL: begin
                        if (wr_phase_q) begin
                            state_q <= S_WR_REQ;
                            req_q   <= 1'b1;
                        end else if (words_q < len_q) begin
                            state_q <= S_RD_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    S_ERR: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master: slave/arbiter models, a vector table of copies,
// and hand sequences for zero length, timeout, grant loss and mid-transfer reset.
module tb_bus_dma_master;
    import bus_dma_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done, error;
    logic [15:0] words_done;
    logic        req, ack;
    logic [31:0] bus_in, bus_out;
    logic [7:0]  ctrl_in, ctrl_out;

    bus_dma_master #(
        .BUS_WIDTH(32), .CTRL_WIDTH(8), .LEN_WIDTH(16), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .error(error), .words_done(words_done),
        .req(req), .ack(ack), .bus_in(bus_in), .bus_out(bus_out),
        .ctrl_in(ctrl_in), .ctrl_out(ctrl_out)
    );

    always #5 clk = ~clk;

    // Arbiter: grants whenever requested unless a competing master holds the bus.
    bit block_ack = 1'b0;
    assign ack = req & ~block_ack;

    // Slave: memory word at address a holds {8'hD0, a[23:0]}; ready after lat wait cycles.
    int          lat = 2;
    bit          never_ready = 1'b0;
    logic        rdy_q = 1'b0;
    logic [31:0] sbus_q = '0;
    logic [31:0] s_addr = '0;
    bit          s_wr = 1'b0;
    int          s_cnt = 0;
    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];

    assign bus_in  = sbus_q;
    assign ctrl_in = {7'b0, rdy_q};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hD0, a[23:0]};
    endfunction

    always @(posedge clk) begin
        rdy_q  <= 1'b0;
        sbus_q <= '0;
        if (rst) begin
            s_cnt <= 0;
        end else if (ctrl_out == CMD_READ) begin
            s_addr <= bus_out; s_wr <= 1'b0; s_cnt <= lat;
        end else if (ctrl_out == CMD_WRITE) begin
            s_addr <= bus_out; s_wr <= 1'b1; s_cnt <= lat;
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 1 && !never_ready) begin
                rdy_q <= 1'b1;
                if (!s_wr) sbus_q <= mem_word(s_addr);
            end
        end
        if (rdy_q && s_wr && ctrl_out == CMD_WDATA) begin
            wlog_a.push_back(s_addr);
            wlog_d.push_back(bus_out);
        end
    end

    // Bus monitors sampled on the falling edge.
    int done_cnt = 0, viol_cnt = 0, gap_bad = 0, gap_cnt = 0, act_cnt = 0, req_cnt = 0;
    int gap_len = 0;
    bit seen_req = 1'b0;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (!ack && (bus_out != '0 || ctrl_out != '0)) viol_cnt <= viol_cnt + 1;
        if (req || busy || ctrl_out != '0) act_cnt <= act_cnt + 1;
        if (req) req_cnt <= req_cnt + 1;
        if (!busy) begin
            seen_req <= 1'b0;
            gap_len  <= 0;
        end else if (req) begin
            if (gap_len != 0) begin
                gap_cnt <= gap_cnt + 1;
                if (gap_len != 1) gap_bad <= gap_bad + 1;
            end
            gap_len  <= 0;
            seen_req <= 1'b1;
        end else if (seen_req) begin
            gap_len <= gap_len + 1;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 1500 && !ok; c++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          lat;
        int          hold;
        bit          restart;
        logic [31:0] last_waddr;
        logic [31:0] last_wdata;
    } vec_t;

    vec_t vecs[5];

    task automatic run_row(input vec_t v, input int idx);
        int    wb, db, vb, gb, gc, n;
        bit    ok;
        string tag;
        tag = $sformatf("row%0d", idx);
        lat = v.lat;
        never_ready = 1'b0;
        block_ack = (v.hold != 0);
        wb = wlog_a.size(); db = done_cnt; vb = viol_cnt; gb = gap_bad; gc = gap_cnt;
        pulse_start(v.src, v.dst, v.len);
        if (v.hold != 0) begin
            repeat (v.hold) @(negedge clk);
            check({tag, "_hold_req"}, 32'(req), 32'd1);
            check({tag, "_hold_bus"}, bus_out, 32'd0);
            block_ack = 1'b0;
        end
        if (v.restart) begin
            repeat (3) @(negedge clk);
            pulse_start(32'h999, 32'h999, 16'd9);
        end
        wait_done(ok);
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words_done"}, 32'(words_done), 32'(v.len));
        check({tag, "_done_pulses"}, 32'(done_cnt - db), 32'd1);
        n = wlog_a.size() - wb;
        check({tag, "_writes"}, 32'(n), 32'(v.len));
        check({tag, "_last_waddr"}, (n > 0) ? wlog_a[wlog_a.size()-1] : 32'hx, v.last_waddr);
        check({tag, "_last_wdata"}, (n > 0) ? wlog_d[wlog_d.size()-1] : 32'hx, v.last_wdata);
        for (int i = 0; i < int'(v.len) && i < n; i++) begin
            check($sformatf("%s_waddr%0d", tag, i), wlog_a[wb+i], v.dst + 32'(i));
            check($sformatf("%s_wdata%0d", tag, i), wlog_d[wb+i], mem_word(v.src + 32'(i)));
        end
        check({tag, "_drive_no_ack"}, 32'(viol_cnt - vb), 32'd0);
        check({tag, "_req_gap_len"}, 32'(gap_bad - gb), 32'd0);
        check({tag, "_req_gaps"}, 32'(gap_cnt - gc), 32'(2 * int'(v.len) - 1));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok, found;
        int n, ab, db, rb;

        vecs[0] = '{32'h10, 32'h100, 16'd4, 2, 0, 1'b0, 32'h103, 32'hD000_0013};
        vecs[1] = '{32'h20, 32'hFFFF_FFFF, 16'd2, 1, 0, 1'b0, 32'h0, 32'hD000_0021};
        vecs[2] = '{32'h30, 32'h200, 16'd3, 1, 10, 1'b0, 32'h202, 32'hD000_0032};
        vecs[3] = '{32'hFFFF_FFFE, 32'h40, 16'd3, 3, 0, 1'b0, 32'h42, 32'hD000_0000};
        vecs[4] = '{32'h50, 32'h60, 16'd2, 2, 0, 1'b1, 32'h61, 32'hD000_0051};

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words_done", 32'(words_done), 32'd0);
        check("rst_bus_out", bus_out, 32'd0);
        check("rst_ctrl_out", 32'(ctrl_out), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) run_row(vecs[i], i);

        // Zero-length copy: done the cycle after start, no bus request.
        @(posedge clk); #1 rb = req_cnt;
        pulse_start(32'h10, 32'h20, 16'd0);
        @(negedge clk);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd1);
        check("len0_words_done", 32'(words_done), 32'd0);
        @(negedge clk);
        check("len0_done_after", 32'(done), 32'd0);
        check("len0_busy_after", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("len0_req_cycles", 32'(req_cnt - rb), 32'd0);

        // Silent slave: eight wait cycles then ERR.
        never_ready = 1'b1; lat = 2;
        pulse_start(32'h70, 32'h80, 16'd1);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (ctrl_out == CMD_READ) found = 1'b1;
        end
        check("tmo_read_seen", 32'(found), 32'd1);
        n = 0;
        for (int c = 0; c < 50 && error !== 1'b1; c++) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles_to_err", 32'(n), 32'd9);
        check("tmo_req_in_err", 32'(req), 32'd0);
        @(negedge clk);
        check("tmo_busy_after", 32'(busy), 32'd0);
        check("tmo_error_sticky", 32'(error), 32'd1);
        never_ready = 1'b0;
        pulse_start(32'h70, 32'h80, 16'd1);
        @(negedge clk);
        check("tmo_error_cleared", 32'(error), 32'd0);
        wait_done(ok);
        check("tmo_retry_done", 32'(ok), 32'd1);
        @(posedge clk); #1;
        check("tmo_retry_words", 32'(words_done), 32'd1);
        check("tmo_retry_waddr", wlog_a[wlog_a.size()-1], 32'h80);
        check("tmo_retry_wdata", wlog_d[wlog_d.size()-1], 32'hD000_0070);

        // Grant withdrawn during the write data phase.
        repeat (4) @(negedge clk);
        lat = 3;
        pulse_start(32'h1000, 32'h2000, 16'd1);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (ctrl_out == CMD_WDATA) found = 1'b1;
        end
        check("ackdrop_wdata_seen", 32'(found), 32'd1);
        block_ack = 1'b1;
        #1;
        check("ackdrop_bus_zero", bus_out, 32'd0);
        @(negedge clk);
        check("ackdrop_error", 32'(error), 32'd1);
        check("ackdrop_req", 32'(req), 32'd0);
        @(negedge clk);
        check("ackdrop_busy", 32'(busy), 32'd0);
        block_ack = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during the data phase of the second word.
        lat = 2;
        pulse_start(32'h90, 32'hA0, 16'd3);
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (ctrl_out == CMD_WDATA && words_done == 16'd1) found = 1'b1;
        end
        check("rstmid_word2_seen", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_req", 32'(req), 32'd0);
        check("rstmid_ctrl_out", 32'(ctrl_out), 32'd0);
        check("rstmid_words_done", 32'(words_done), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        ab = act_cnt; db = done_cnt;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        check("rstmid_activity_after", 32'(act_cnt - ab), 32'd0);
        check("rstmid_done_pulses", 32'(done_cnt - db), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
